// File: rtl/countdown_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : countdown_ctrl_pkg
// Brief  : State type and default tick divider shared by the countdown
//          control stage and its prescaler.
// Rev    : 1.0 - initial release
// ============================================================================
package countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One count tick per second at a 100 MHz system clock
    localparam int unsigned c_DEFAULT_TICK_DIV = 100_000_000;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module : tick_prescaler
// Brief  : Modulo-TICK_DIV cycle counter with enable, synchronous clear and
//          a terminal-count flag (high while the count sits at TICK_DIV-1).
// Rev    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned        c_CNT_W = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_count;

    assign tc = (r_count == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= tc ? '0 : r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module : countdown_ctrl
// Brief  : Run/pause/done control for the BCD countdown chain; paces the
//          LS-digit decrease strobe and issues the preset reload strobe.
//          Optional display blink in PAUSE/DONE: COUNTDOWN_CTRL_BLINK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = c_DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic start_pause,
    input  logic clear,
    input  logic count_zero,
    output logic decrease,
    output logic reload,
    output logic running,
    output logic done,
    output logic disp_on
);

    state_t r_state;
    state_t w_next;
    logic   w_pre_en;
    logic   w_pre_clr;
    logic   w_tc;

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start_pause && !count_zero) w_next = RUN;
                RUN: begin
                    if (count_zero)       w_next = DONE;
                    else if (start_pause) w_next = PAUSE;
                end
                PAUSE:   if (start_pause) w_next = RUN;
                default: w_next = r_state;
            endcase
        end
    end

    // Prescaler freezes on the pausing cycle so a resumed second keeps its phase
    assign w_pre_en  = (r_state == RUN) && (w_next == RUN);
    assign w_pre_clr = clear || (w_next == IDLE) || (w_next == DONE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (w_pre_en),
        .clr (w_pre_clr),
        .tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            decrease <= 1'b0;
            reload   <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_next;
            decrease <= w_pre_en && w_tc && !count_zero;
            reload   <= clear;
            running  <= (w_next == RUN);
            done     <= (w_next == DONE);
        end
    end

`ifdef COUNTDOWN_CTRL_BLINK_EN
    localparam int unsigned         c_HALF_DIV  = TICK_DIV / 2;
    localparam int unsigned         c_HALF_W    = $clog2(c_HALF_DIV);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(c_HALF_DIV - 1);

    logic [c_HALF_W-1:0] r_half_cnt;
    logic                w_blink_st;

    assign w_blink_st = (w_next == PAUSE) || (w_next == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half_cnt <= '0;
            disp_on    <= 1'b1;
        end else if (!w_blink_st) begin
            r_half_cnt <= '0;
            disp_on    <= 1'b1;
        end else if (w_next != r_state) begin
            r_half_cnt <= '0;
            disp_on    <= 1'b0;
        end else if (r_half_cnt == c_HALF_LAST) begin
            r_half_cnt <= '0;
            disp_on    <= ~disp_on;
        end else begin
            r_half_cnt <= r_half_cnt + c_HALF_W'(1);
        end
    end
`else
    assign disp_on = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_countdown_ctrl
// Brief  : Self-checking bench for countdown_ctrl at TICK_DIV=4.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

    localparam int unsigned c_TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_pause = 1'b0;
    logic clear = 1'b0;
    logic count_zero = 1'b0;
    logic decrease, reload, running, done, disp_on;

    int n_pass  = 0;
    int n_total = 0;

    countdown_ctrl #(
        .TICK_DIV (c_TD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_pause (start_pause),
        .clear       (clear),
        .count_zero  (count_zero),
        .decrease    (decrease),
        .reload      (reload),
        .running     (running),
        .done        (done),
        .disp_on     (disp_on)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 run, 2 paused, 3 finished
    int m_mode    = 0;
    int m_elapsed = 0;
    int m_blink   = 0;
    bit m_dec     = 0;
    bit m_rel     = 0;

    function automatic void model_reset();
        m_mode = 0; m_elapsed = 0; m_blink = 0; m_dec = 0; m_rel = 0;
    endfunction

    function automatic void model_edge(bit sp, bit clr, bit cz);
        int prev;
        prev  = m_mode;
        m_rel = clr;
        m_dec = 0;
        if (clr) begin
            m_mode = 0;
            m_elapsed = 0;
        end else begin
            case (m_mode)
                0: if (sp && !cz) m_mode = 1;
                1: begin
                    if (cz) begin
                        m_mode = 3;
                        m_elapsed = 0;
                    end else if (sp) begin
                        m_mode = 2;
                    end else if (m_elapsed == c_TD - 1) begin
                        m_dec = 1;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
                2: if (sp) m_mode = 1;
                default: ;
            endcase
        end
        if (m_mode == 2 || m_mode == 3) m_blink = (m_mode != prev) ? 0 : m_blink + 1;
        else m_blink = 0;
    endfunction

    function automatic bit model_disp();
`ifdef COUNTDOWN_CTRL_BLINK_EN
        if (m_mode == 2 || m_mode == 3) return ((m_blink / (c_TD / 2)) % 2) == 1;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_running"}, running, m_mode == 1);
        chk({nm, "_done"}, done, m_mode == 3);
        chk({nm, "_decrease"}, decrease, m_dec);
        chk({nm, "_reload"}, reload, m_rel);
        chk({nm, "_disp_on"}, disp_on, model_disp());
    endtask

    task automatic step(input bit sp, input bit clr, input bit cz);
        @(negedge clk);
        start_pause = sp; clear = clr; count_zero = cz;
        @(posedge clk);
        model_edge(sp, clr, cz);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start_pause = 1'b0; clear = 1'b0; count_zero = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit    sp, clr, cz;
        bit    e_run, e_done, e_dec, e_rel;
        string name;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    task automatic apply_vec(input vec_t v);
        step(v.sp, v.clr, v.cz);
        chk({v.name, "_running"}, running, v.e_run);
        chk({v.name, "_done"}, done, v.e_done);
        chk({v.name, "_decrease"}, decrease, v.e_dec);
        chk({v.name, "_reload"}, reload, v.e_rel);
    endtask

    initial begin
        bit sp, clr, cz;
        bit blink_exp[6];

        tab_a.push_back('{1,0,1, 0,0,0,0, "idle_sp_with_zero"});
        tab_a.push_back('{1,0,0, 1,0,0,0, "start"});
        tab_a.push_back('{0,0,0, 1,0,0,0, "run_c1"});
        tab_a.push_back('{0,0,0, 1,0,0,0, "run_c2"});
        tab_a.push_back('{0,0,0, 1,0,0,0, "run_c3"});
        tab_a.push_back('{0,0,0, 1,0,1,0, "first_dec"});
        tab_a.push_back('{0,0,0, 1,0,0,0, "run_c5"});
        tab_a.push_back('{0,0,0, 1,0,0,0, "run_c6"});
        tab_a.push_back('{0,0,0, 1,0,0,0, "run_c7"});
        tab_a.push_back('{0,0,0, 1,0,1,0, "second_dec"});
        tab_a.push_back('{0,0,0, 1,0,0,0, "after_dec"});
        tab_a.push_back('{0,0,1, 0,1,0,0, "enter_done"});
        tab_a.push_back('{1,0,1, 0,1,0,0, "done_sp_ignored"});

        tab_b.push_back('{0,1,1, 0,0,0,1, "clear_from_done"});
        tab_b.push_back('{0,0,1, 0,0,0,0, "reload_one_cycle"});
        tab_b.push_back('{1,0,0, 1,0,0,0, "restart"});
        tab_b.push_back('{0,0,0, 1,0,0,0, "rerun_c1"});
        tab_b.push_back('{0,0,0, 1,0,0,0, "rerun_c2"});
        tab_b.push_back('{0,0,0, 1,0,0,0, "rerun_c3"});
        tab_b.push_back('{1,1,0, 0,0,0,1, "clr_sp_at_tc"});
        tab_b.push_back('{0,0,0, 0,0,0,0, "no_dec_after_clr"});

        do_reset();
        #1;
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_decrease", decrease, 1'b0);
        chk("rst_reload", reload, 1'b0);
        chk("rst_disp_on", disp_on, 1'b1);

        foreach (tab_a[i]) apply_vec(tab_a[i]);

        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1);
            chk("done_hold_decrease", decrease, 1'b0);
            chk("done_hold_done", done, 1'b1);
            chk("done_blink", disp_on, model_disp());
        end

        foreach (tab_b[i]) apply_vec(tab_b[i]);

        // Pause at prescaler 2, watch blink, resume and expect the tick 2 cycles later
`ifdef COUNTDOWN_CTRL_BLINK_EN
        blink_exp = '{0, 0, 1, 1, 0, 0};
`else
        blink_exp = '{1, 1, 1, 1, 1, 1};
`endif
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("pause_running", running, 1'b0);
        chk("pause_decrease", decrease, 1'b0);
        chk("pause_disp_0", disp_on, blink_exp[0]);
        for (int i = 1; i < 6; i++) begin
            step(0, 0, 0);
            chk("pause_disp", disp_on, blink_exp[i]);
            chk("pause_hold_decrease", decrease, 1'b0);
        end
        step(1, 0, 0);
        chk("resume_running", running, 1'b1);
        chk("resume_disp_on", disp_on, 1'b1);
        chk("resume_c0_decrease", decrease, 1'b0);
        step(0, 0, 0);
        chk("resume_c1_decrease", decrease, 1'b0);
        step(0, 0, 0);
        chk("resume_c2_decrease", decrease, 1'b1);

        // Asynchronous reset while the decrease strobe is high
        @(negedge clk);
        rst = 1'b1; start_pause = 1'b0; clear = 1'b0; count_zero = 1'b0;
        #1;
        chk("async_rst_running", running, 1'b0);
        chk("async_rst_decrease", decrease, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_disp_on", disp_on, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        cz = 0;
        for (int i = 0; i < 500; i++) begin
            sp  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) cz = ~cz;
            step(sp, clr, cz);
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_ctrl.md
# countdown_ctrl

Control stage that sits directly upstream of the BCD down-counter digit chain in the countdown timer. It turns one-pulse button events (start/pause, clear) into a one-second `decrease` strobe for the least-significant digit, and a `reload` strobe that restores the preset. It watches the chain's all-zero flag to stop at 00:00. Digit borrow chaining stays in the digit counters; this block only paces and gates them.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per count tick. Must be ≥ 4 and even.
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous reset, active-high
- `start_pause`  in  1  one-cycle pulse from the debounce/one-pulse stage; toggles run/pause
- `clear`  in  1  one-cycle pulse; abort and restore preset
- `count_zero`  in  1  high when every digit of the downstream chain reads 0
- `decrease`  out  1  registered one-cycle strobe to the LS digit counter
- `reload`  out  1  registered one-cycle strobe; top level forms the digits' active-low reset as ~(rst | reload)
- `running`  out  1  high in RUN
- `done`  out  1  high in DONE
- `disp_on`  out  1  display enable; blinks in PAUSE/DONE when the blink feature is built

## Operation
- States: IDLE (reset state), RUN, PAUSE, DONE.
- Priority each cycle: `clear` > `count_zero` (RUN only) > `start_pause`.
- `clear` in any state: go to IDLE, pulse `reload` next cycle, prescaler to 0.
- IDLE: `start_pause` with `count_zero`=0 → RUN. With `count_zero`=1 it is ignored and the block stays in IDLE.
- RUN: `count_zero`=1 → DONE. `start_pause` → PAUSE.
- PAUSE: `start_pause` → RUN. Prescaler holds its value, so a resumed second completes its remaining cycles.
- DONE: `start_pause` ignored. Only `clear` leaves.
- Prescaler: counts 0..TICK_DIV-1 only in RUN, then wraps to 0. Cleared in IDLE and DONE.
- Registered `decrease` is asserted the cycle after a cycle where all of these hold:
  - state is RUN and next state is RUN;
  - prescaler = TICK_DIV-1;
  - `count_zero`=0.
- If a terminal count coincides with `start_pause` or `clear`, no `decrease` is issued.
- `running`/`done` are Moore outputs, registered with the state.
- Reset values:
  - state IDLE, prescaler 0;
  - `decrease` 0, `reload` 0, `running` 0, `done` 0, `disp_on` 1.

## Timing
- Start press at edge N: state is RUN after edge N. First `decrease` is high in cycle N+TICK_DIV; the digit changes at the following edge.
- Tick period in RUN is exactly TICK_DIV cycles, measured between `decrease` rising edges.
- Last digit reaching 0: `count_zero` rises 1 cycle after the final `decrease`. The FSM enters DONE on the next edge.
- No further `decrease` follows, because TICK_DIV ≥ 4.
- `reload` is high exactly 1 cycle, the cycle after `clear` is sampled.
- `rst` asserted mid-count: all outputs return to reset values immediately (asynchronous). Digits are reset by the same `rst` through the top-level OR.

## Configuration
- `COUNTDOWN_CTRL_BLINK_EN` defined:
  - a half-tick counter runs in PAUSE and DONE;
  - `disp_on` starts at 0 on state entry and toggles every TICK_DIV/2 cycles;
  - `disp_on` = 1 in IDLE and RUN.
- Macro undefined: `disp_on` is tied to 1 and the half-tick counter is not built.

## Structure
- Package `countdown_ctrl_pkg`: state enum typedef (IDLE/RUN/PAUSE/DONE) and the default tick constant.
- One sub-module, `tick_prescaler`. Ports: enable, synchronous clear, terminal-count output; width derived from TICK_DIV via $clog2.
- FSM, output registers and the blink logic stay in `countdown_ctrl`.

## Test plan
- All scenarios use TICK_DIV=4.
- Reset → IDLE, all outputs 0 except `disp_on`=1. Pulse `start_pause` with `count_zero`=0 → `running`=1. `decrease` pulses every 4 cycles, first one 4 cycles after start.
- RUN, pulse `start_pause` at prescaler=2 → PAUSE, no `decrease`. Resume → next `decrease` exactly 2 cycles later.
- RUN, raise `count_zero` 1 cycle after a `decrease` → DONE next edge, `done`=1, no further `decrease` for 20 cycles. `start_pause` is ignored.
- DONE, pulse `clear` → IDLE, `reload`=1 for exactly 1 cycle, `done`=0.
- `clear` and `start_pause` in the same cycle as a terminal count → IDLE, no `decrease`, `reload` pulse. Also check `start_pause` in IDLE with `count_zero`=1 → stays IDLE.
- With `COUNTDOWN_CTRL_BLINK_EN`: in PAUSE, `disp_on` reads 0,0,1,1,0,0… Without the macro, `disp_on` stays 1. Also assert `rst` mid-RUN → immediate IDLE.
